axi_reorder_buffer: RTL
=======================

# axi_reorder_buffer

AXI read-channel reorder buffer with burst support. Sits between an in-order upstream AXI read master and a downstream slave that may return responses out of order. Each accepted AR is tagged with a buffer slot index on the downstream side. Returned R beats are stored per slot and replayed upstream in AR-acceptance order with the original ID restored. Unlike the single-beat, fixed-size predecessor, depth, ID width and burst length are parametrised, and RRESP, RLAST and a protocol error flag are added.

## Interface
- DATA_WIDTH, 8, R data width
- ID_WIDTH, 4, upstream ID width
- DEPTH, 16, outstanding transactions (power of 2, ≥2); SW = $clog2(DEPTH)
- MAX_BEATS, 4, max beats per burst (power of 2, ≥2); LW = $clog2(MAX_BEATS)
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset; asynchronous assert, active-low
- s_arid_i  in  ID_WIDTH  upstream AR ID
- s_arlen_i  in  LW  upstream burst length minus 1
- s_arvalid_i / s_arready_o  in / out  1  upstream AR handshake
- m_arid_o  out  SW  allocated slot index
- m_arlen_o  out  LW  forwarded s_arlen_i
- m_arvalid_o / m_arready_i  out / in  1  downstream AR handshake
- m_rdata_i  in  DATA_WIDTH  downstream R data
- m_rid_i  in  SW  slot index of the returned beat
- m_rresp_i  in  2  response code
- m_rlast_i  in  1  last beat of burst
- m_rvalid_i / m_rready_o  in / out  1  downstream R handshake
- s_rdata_o  out  DATA_WIDTH  upstream R data
- s_rid_o  out  ID_WIDTH  original ID
- s_rresp_o  out  2  stored response code
- s_rlast_o  out  1  last beat
- s_rvalid_o / s_rready_i  out / in  1  upstream R handshake
- err_o  out  1  sticky protocol-error flag

## Operation
- Slot state: allocated bit, orig_id, len, rcv_cnt, DATA+2-bit storage × MAX_BEATS. Also wr_ptr, rd_ptr, out_cnt, count (0..DEPTH).
- AR path (combinational, zero latency):
  - full = (count==DEPTH)
  - m_arvalid_o = s_arvalid_i & ~full
  - s_arready_o = m_arready_i & ~full
  - m_arid_o = wr_ptr
  - On handshake: slot[wr_ptr] gets allocated=1, orig_id, len, rcv_cnt=0; wr_ptr++ (wraps mod DEPTH).
- R input:
  - m_rready_o = 1 whenever out of reset.
  - Beat to an allocated slot with rcv_cnt ≤ len: stored at index rcv_cnt, then rcv_cnt++.
  - Beats of different slots may interleave freely.
  - Beat to an unallocated slot, or a beat beyond len: dropped, err_o set.
  - m_rlast_i ≠ (rcv_cnt==len): beat is stored anyway, err_o set.
- R output, cut-through per beat from the head slot rd_ptr:
  - s_rvalid_o = slot[rd_ptr].allocated & (out_cnt < rcv_cnt)
  - Data and resp come from storage[rd_ptr][out_cnt].
  - s_rid_o = orig_id; s_rlast_o = (out_cnt==len).
  - On handshake: out_cnt++.
  - On last-beat handshake: slot freed, out_cnt=0, rd_ptr++.
- count: +1 on alloc, −1 on free, unchanged when both happen in the same cycle.
- err_o: set by any violation; cleared only by reset.

## Timing
- While rst_n is low, and on reset exit: s_arready_o=0, m_arvalid_o=0, m_rready_o=0, s_rvalid_o=0, err_o=0; all slots free; pointers, count and out_cnt are 0.
- AR forwarding latency: 0 cycles.
- A beat accepted at edge N can be presented upstream from cycle N+1. There is no same-cycle bypass.
- When full, a slot freed at edge N makes s_arready_o available from cycle N+1; a freed slot is never reused in the same cycle.
- s_rvalid_o never drops without a handshake. s_rdata_o, s_rid_o, s_rresp_o and s_rlast_o stay stable while s_rvalid_o=1 and s_rready_i=0.
- Reset mid-operation: all in-flight state is discarded. Post-reset beats for old slots count as unallocated and set err_o.

## Test plan
- Default params, 16 ARs with IDs 0..15 and len 0; downstream returns in shuffled order, data = slot+0x10 → upstream sees IDs 0..15 in order, data 0x10..0x1F, every beat with rlast=1, err_o=0.
- 16 ARs outstanding, 17th AR held → m_arvalid_o=0 and s_arready_o=0 until the head burst completes; accepted the cycle after the free, m_arid_o=0 (wrap).
- Slot0 len=3, slot1 len=1; downstream beats in order S1,S0,S1,S0,S0,S0 → upstream emits 4 slot0 beats (rlast on the 4th), then 2 slot1 beats (rlast on the 2nd).
- Two ARs with ID 5 → m_arid_o 0 then 1; slot1 returned first with resp=2'b10 → upstream outputs slot0 data, then slot1 data with s_rresp_o=2'b10, both with s_rid_o=5.
- s_rready_i held low 10 cycles with beats pending → outputs stable, m_rready_o stays 1, no loss; all beats drain in order after release.
- Beat with m_rid_i=3 while slot3 is unallocated → dropped, err_o=1 from the next cycle and held. Then assert rst_n low mid-burst → all outputs idle, err_o=0, next AR gets m_arid_o=0.

Source files
------------

// File: rtl/axi_reorder_buffer.sv
// AXI read-channel reorder buffer: tags each AR with a slot index downstream,
// stores out-of-order R beats per slot and replays them upstream in AR order
// with the original ID restored.
module axi_reorder_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned MAX_BEATS  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ID_WIDTH-1:0]          s_arid_i,
   input  logic [$clog2(MAX_BEATS)-1:0] s_arlen_i,
   input  logic                         s_arvalid_i,
   output logic                         s_arready_o,
   output logic [$clog2(DEPTH)-1:0]     m_arid_o,
   output logic [$clog2(MAX_BEATS)-1:0] m_arlen_o,
   output logic                         m_arvalid_o,
   input  logic                         m_arready_i,
   input  logic [DATA_WIDTH-1:0]        m_rdata_i,
   input  logic [$clog2(DEPTH)-1:0]     m_rid_i,
   input  logic [1:0]                   m_rresp_i,
   input  logic                         m_rlast_i,
   input  logic                         m_rvalid_i,
   output logic                         m_rready_o,
   output logic [DATA_WIDTH-1:0]        s_rdata_o,
   output logic [ID_WIDTH-1:0]          s_rid_o,
   output logic [1:0]                   s_rresp_o,
   output logic                         s_rlast_o,
   output logic                         s_rvalid_o,
   input  logic                         s_rready_i,
   output logic                         err_o
);

   localparam int unsigned SW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(MAX_BEATS);
   localparam int unsigned CW = SW + 1;         // occupancy 0..DEPTH
   localparam int unsigned RW = LW + 1;         // received beats 0..MAX_BEATS
   localparam int unsigned EW = DATA_WIDTH + 2; // stored {resp, data}
   localparam int unsigned AW = SW + LW;        // storage index {slot, beat}

   logic                run_q;
   logic                err_q;
   logic [DEPTH-1:0]    alloc_q;
   logic [ID_WIDTH-1:0] id_q   [DEPTH];
   logic [LW-1:0]       len_q  [DEPTH];
   logic [RW-1:0]       rcv_q  [DEPTH];
   logic [EW-1:0]       mem_q  [DEPTH*MAX_BEATS];
   logic [SW-1:0]       wr_ptr_q;
   logic [SW-1:0]       rd_ptr_q;
   logic [LW-1:0]       out_cnt_q;
   logic [CW-1:0]       count_q;

   logic          full_c;
   logic          ar_hs_c;
   logic          beat_c;
   logic          beat_ok_c;
   logic          beat_last_c;
   logic          beat_err_c;
   logic [RW-1:0] beat_rcv_c;
   logic [AW-1:0] wr_idx_c;
   logic [AW-1:0] rd_idx_c;
   logic [EW-1:0] head_entry_c;
   logic          r_hs_c;
   logic          free_c;

   // AR path: zero-latency pass-through gated by occupancy and reset exit
   assign full_c      = (count_q == CW'(DEPTH));
   assign m_arvalid_o = run_q & s_arvalid_i & ~full_c;
   assign s_arready_o = run_q & m_arready_i & ~full_c;
   assign m_arid_o    = wr_ptr_q;
   assign m_arlen_o   = s_arlen_i;
   assign ar_hs_c     = m_arvalid_o & m_arready_i;

   // R input classification: store, drop, or flag an RLAST mismatch
   assign m_rready_o  = run_q;
   assign beat_c      = run_q & m_rvalid_i;
   assign beat_rcv_c  = rcv_q[m_rid_i];
   assign beat_ok_c   = alloc_q[m_rid_i] & (beat_rcv_c <= RW'(len_q[m_rid_i]));
   assign beat_last_c = (beat_rcv_c == RW'(len_q[m_rid_i]));
   assign beat_err_c  = beat_c & (~beat_ok_c | (m_rlast_i != beat_last_c));
   assign wr_idx_c    = {m_rid_i, beat_rcv_c[LW-1:0]};

   // R output: cut-through from the head slot, one beat behind the store
   assign rd_idx_c     = {rd_ptr_q, out_cnt_q};
   assign head_entry_c = mem_q[rd_idx_c];
   assign s_rvalid_o   = alloc_q[rd_ptr_q] & (RW'(out_cnt_q) < rcv_q[rd_ptr_q]);
   assign s_rdata_o    = head_entry_c[DATA_WIDTH-1:0];
   assign s_rresp_o    = head_entry_c[EW-1:DATA_WIDTH];
   assign s_rid_o      = id_q[rd_ptr_q];
   assign s_rlast_o    = (out_cnt_q == len_q[rd_ptr_q]);
   assign r_hs_c       = s_rvalid_o & s_rready_i;
   assign free_c       = r_hs_c & s_rlast_o;
   assign err_o        = err_q;

   // Control state: allocation, head advance, occupancy and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         err_q     <= 1'b0;
         alloc_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_cnt_q <= '0;
         count_q   <= '0;
      end else begin
         run_q <= 1'b1;
         if (ar_hs_c) begin
            alloc_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + SW'(1);
         end
         if (r_hs_c) begin
            if (free_c) begin
               alloc_q[rd_ptr_q] <= 1'b0;
               out_cnt_q         <= '0;
               rd_ptr_q          <= rd_ptr_q + SW'(1);
            end else begin
               out_cnt_q <= out_cnt_q + LW'(1);
            end
         end
         unique case ({ar_hs_c, free_c})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (beat_err_c) begin
            err_q <= 1'b1;
         end
      end
   end

   // Slot payload: metadata on allocation, beat storage on accepted R beats
   always_ff @(posedge clk) begin
      if (ar_hs_c) begin
         id_q[wr_ptr_q]  <= s_arid_i;
         len_q[wr_ptr_q] <= s_arlen_i;
         rcv_q[wr_ptr_q] <= '0;
      end
      if (beat_c && beat_ok_c) begin
         rcv_q[m_rid_i]  <= beat_rcv_c + RW'(1);
         mem_q[wr_idx_c] <= {m_rresp_i, m_rdata_i};
      end
   end

endmodule
